// File: rtl/msrv32_imm_enc.sv
// Immediate encoder: packs a 32-bit immediate into the RISC-V field layout of a base instruction.
// Results pass through a 2-entry in-order queue with valid/ready handshakes on both sides.
module msrv32_imm_enc (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        in_valid_in,
  output logic        in_ready_out,
  input  logic [2:0]  imm_type_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] base_instr_in,
  output logic        out_valid_out,
  input  logic        out_ready_in,
  output logic [31:0] instr_out,
  output logic        err_out,
  output logic        err_sticky_out,
  input  logic        clr_err_in,
  output logic [15:0] enc_count_out
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t      state, next_state;
  logic [31:0] enc_word;
  logic        enc_err;
  logic [31:0] tail_word;
  logic        tail_err;
  logic        push, pop;
  logic        fits_12, fits_13, fits_21;

  // Each fits_* flag is true when the upper bits are a pure sign extension.
  assign fits_12 = (imm_in[31:11] == '0) || (imm_in[31:11] == '1);
  assign fits_13 = (imm_in[31:12] == '0) || (imm_in[31:12] == '1);
  assign fits_21 = (imm_in[31:20] == '0) || (imm_in[31:20] == '1);

  always_comb begin
    enc_word = base_instr_in;
    enc_err  = 1'b0;
    case (imm_type_in)
      3'b010: begin
        enc_word[31:25] = imm_in[11:5];
        enc_word[11:7]  = imm_in[4:0];
        enc_err         = !fits_12;
      end
      3'b011: begin
        enc_word[31]    = imm_in[12];
        enc_word[7]     = imm_in[11];
        enc_word[30:25] = imm_in[10:5];
        enc_word[11:8]  = imm_in[4:1];
        enc_err         = imm_in[0] || !fits_13;
      end
      3'b100: begin
        enc_word[31:12] = imm_in[31:12];
        enc_err         = (imm_in[11:0] != '0);
      end
      3'b101: begin
        enc_word[31]    = imm_in[20];
        enc_word[19:12] = imm_in[19:12];
        enc_word[20]    = imm_in[11];
        enc_word[30:21] = imm_in[10:1];
        enc_err         = imm_in[0] || !fits_21;
      end
      3'b110: begin
        enc_word[19:15] = imm_in[4:0];
        enc_err         = (imm_in[31:5] != '0);
      end
      default: begin
        enc_word[31:20] = imm_in[11:0];
        enc_err         = !fits_12;
      end
    endcase
  end

  assign push = in_valid_in && in_ready_out;
  assign pop  = out_valid_out && out_ready_in;

  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (push) next_state = ONE;
      ONE: begin
        if (push && !pop)      next_state = TWO;
        else if (pop && !push) next_state = EMPTY;
      end
      TWO:     if (pop) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  // The head entry lives directly in the output registers; tail holds the second word.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= EMPTY;
      in_ready_out   <= 1'b1;
      out_valid_out  <= 1'b0;
      instr_out      <= '0;
      err_out        <= 1'b0;
      tail_word      <= '0;
      tail_err       <= 1'b0;
      err_sticky_out <= 1'b0;
      enc_count_out  <= '0;
    end else begin
      state         <= next_state;
      in_ready_out  <= (next_state != TWO);
      out_valid_out <= (next_state != EMPTY);
      case (state)
        EMPTY: begin
          if (push) begin
            instr_out <= enc_word;
            err_out   <= enc_err;
          end
        end
        ONE: begin
          if (push && pop) begin
            instr_out <= enc_word;
            err_out   <= enc_err;
          end else if (push) begin
            tail_word <= enc_word;
            tail_err  <= enc_err;
          end
        end
        TWO: begin
          if (pop) begin
            instr_out <= tail_word;
            err_out   <= tail_err;
          end
        end
        default: ;
      endcase
      if (push) enc_count_out <= enc_count_out + 16'd1;
      if (push && enc_err)  err_sticky_out <= 1'b1;
      else if (clr_err_in)  err_sticky_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msrv32_imm_enc.sv
// Self-checking bench for msrv32_imm_enc: directed vectors, handshake corner cases and a
// randomized run against a queue-based reference model.
module tb_msrv32_imm_enc;

  logic        clk_in, rst_in;
  logic        in_valid_in, in_ready_out;
  logic [2:0]  imm_type_in;
  logic [31:0] imm_in, base_instr_in;
  logic        out_valid_out, out_ready_in;
  logic [31:0] instr_out;
  logic        err_out, err_sticky_out, clr_err_in;
  logic [15:0] enc_count_out;

  msrv32_imm_enc dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .imm_type_in(imm_type_in), .imm_in(imm_in), .base_instr_in(base_instr_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .instr_out(instr_out), .err_out(err_out),
    .err_sticky_out(err_sticky_out), .clr_err_in(clr_err_in),
    .enc_count_out(enc_count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } word_t;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
    logic        sticky;
  } vec_t;

  word_t       exp_q[$];
  logic [15:0] exp_count;
  logic        exp_sticky;
  int          tests_run = 0;
  int          tests_failed = 0;
  vec_t        vecs[12];

  // Field layout as (destination bit, source bit, width) segments, copied bit by bit.
  function automatic logic [31:0] refEncode(input logic [2:0] t, input logic [31:0] imm,
                                            input logic [31:0] base);
    int dst[4];
    int src[4];
    int w[4];
    int n;
    logic [31:0] r;
    r = base;
    dst = '{0, 0, 0, 0};
    src = '{0, 0, 0, 0};
    w   = '{0, 0, 0, 0};
    case (t)
      3'd2: begin n = 2; dst = '{25, 7, 0, 0}; src = '{5, 0, 0, 0}; w = '{7, 5, 0, 0}; end
      3'd3: begin n = 4; dst = '{31, 7, 25, 8}; src = '{12, 11, 5, 1}; w = '{1, 1, 6, 4}; end
      3'd4: begin n = 1; dst[0] = 12; src[0] = 12; w[0] = 20; end
      3'd5: begin n = 4; dst = '{31, 12, 20, 21}; src = '{20, 12, 11, 1}; w = '{1, 8, 1, 10}; end
      3'd6: begin n = 1; dst[0] = 15; src[0] = 0; w[0] = 5; end
      default: begin n = 1; dst[0] = 20; src[0] = 0; w[0] = 12; end
    endcase
    for (int i = 0; i < n; i++)
      for (int k = 0; k < w[i]; k++)
        r[dst[i] + k] = imm[src[i] + k];
    return r;
  endfunction

  // Representability judged on the numeric value of the immediate.
  function automatic logic refError(input logic [2:0] t, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (t)
      3'd2:    return (s < -2048) || (s > 2047);
      3'd3:    return (imm[0] == 1'b1) || (s < -4096) || (s > 4095);
      3'd4:    return (imm % 4096) != 0;
      3'd5:    return (imm[0] == 1'b1) || (s < -(longint'(1) << 20)) || (s >= (longint'(1) << 20));
      3'd6:    return imm > 32'd31;
      default: return (s < -2048) || (s > 2047);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("out_valid", {31'd0, out_valid_out}, {31'd0, exp_q.size() > 0});
    checkOutput("in_ready", {31'd0, in_ready_out}, {31'd0, exp_q.size() < 2});
    checkOutput("enc_count", {16'd0, enc_count_out}, {16'd0, exp_count});
    checkOutput("err_sticky", {31'd0, err_sticky_out}, {31'd0, exp_sticky});
    if (exp_q.size() > 0) begin
      checkOutput("instr", instr_out, exp_q[0].instr);
      checkOutput("err", {31'd0, err_out}, {31'd0, exp_q[0].err});
    end
  endtask

  // Drive inputs, advance the model across the rising edge, then check on the falling edge.
  task automatic applyStimulus(input logic v, input logic [2:0] t, input logic [31:0] imm,
                               input logic [31:0] base, input logic rdy, input logic clr);
    word_t w;
    logic  do_push, do_pop;
    in_valid_in   = v;
    imm_type_in   = t;
    imm_in        = imm;
    base_instr_in = base;
    out_ready_in  = rdy;
    clr_err_in    = clr;
    @(posedge clk_in);
    do_push = v && (exp_q.size() < 2);
    do_pop  = rdy && (exp_q.size() > 0);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      w.instr = refEncode(t, imm, base);
      w.err   = refError(t, imm);
      exp_q.push_back(w);
      exp_count++;
      if (w.err) exp_sticky = 1'b1;
      else if (clr) exp_sticky = 1'b0;
    end else if (clr) begin
      exp_sticky = 1'b0;
    end
    @(negedge clk_in);
    checkModel();
  endtask

  task automatic resetPulse();
    in_valid_in = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    exp_q.delete();
    exp_count  = '0;
    exp_sticky = 1'b0;
    checkOutput("rst_valid", {31'd0, out_valid_out}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready_out}, 32'd1);
    checkOutput("rst_instr", instr_out, 32'd0);
    checkOutput("rst_err", {31'd0, err_out}, 32'd0);
    checkOutput("rst_sticky", {31'd0, err_sticky_out}, 32'd0);
    checkOutput("rst_count", {16'd0, enc_count_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0, 1'b0};
    vecs[1]  = '{3'b011, 32'h00000801, 32'h00000063, 32'h000000E3, 1'b1, 1'b1};
    vecs[2]  = '{3'b100, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0, 1'b1};
    vecs[3]  = '{3'b101, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1, 1'b1};
    vecs[4]  = '{3'b010, 32'h0000007F, 32'h00002023, 32'h06002FA3, 1'b0, 1'b1};
    vecs[5]  = '{3'b110, 32'h0000001F, 32'h00001073, 32'h000F9073, 1'b0, 1'b1};
    vecs[6]  = '{3'b110, 32'h00000020, 32'hFFFFFFFF, 32'hFFF07FFF, 1'b1, 1'b1};
    vecs[7]  = '{3'b111, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1, 1'b1};
    vecs[8]  = '{3'b101, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b0, 1'b1};
    vecs[9]  = '{3'b100, 32'h00000001, 32'hFFFFFFFF, 32'h00000FFF, 1'b1, 1'b1};
    vecs[10] = '{3'b011, 32'hFFFFF000, 32'h00000000, 32'h80000000, 1'b0, 1'b1};
    vecs[11] = '{3'b001, 32'h000007FF, 32'h00000000, 32'h7FF00000, 1'b0, 1'b1};

    rst_in = 1'b0;
    in_valid_in = 1'b0; imm_type_in = '0; imm_in = '0; base_instr_in = '0;
    out_ready_in = 1'b0; clr_err_in = 1'b0;
    exp_count = '0; exp_sticky = 1'b0;
    repeat (2) @(negedge clk_in);
    resetPulse();

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].t, vecs[i].imm, vecs[i].base, 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, out_valid_out}, 32'd1);
      checkOutput($sformatf("vec%0d_instr", i), instr_out, vecs[i].instr);
      checkOutput($sformatf("vec%0d_err", i), {31'd0, err_out}, {31'd0, vecs[i].err});
      checkOutput($sformatf("vec%0d_sticky", i), {31'd0, err_sticky_out}, {31'd0, vecs[i].sticky});
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    end

    $display("[TB] backpressure");
    resetPulse();
    applyStimulus(1'b1, 3'd0, 32'd1, 32'h13, 1'b0, 1'b0);
    checkOutput("bp_ready_after_a", {31'd0, in_ready_out}, 32'd1);
    applyStimulus(1'b1, 3'd0, 32'd2, 32'h13, 1'b0, 1'b0);
    checkOutput("bp_ready_after_b", {31'd0, in_ready_out}, 32'd0);
    checkOutput("bp_hold_a", instr_out, 32'h00100013);
    applyStimulus(1'b1, 3'd0, 32'd3, 32'h13, 1'b0, 1'b0);
    checkOutput("bp_c_held_count", {16'd0, enc_count_out}, 32'd2);
    checkOutput("bp_still_a", instr_out, 32'h00100013);
    applyStimulus(1'b1, 3'd0, 32'd3, 32'h13, 1'b1, 1'b0);
    checkOutput("bp_out_b", instr_out, 32'h00200013);
    applyStimulus(1'b1, 3'd0, 32'd3, 32'h13, 1'b1, 1'b0);
    checkOutput("bp_out_c", instr_out, 32'h00300013);
    checkOutput("bp_count", {16'd0, enc_count_out}, 32'd3);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("bp_drained", {31'd0, out_valid_out}, 32'd0);

    $display("[TB] sticky set versus clear");
    applyStimulus(1'b1, 3'd3, 32'h1, 32'h63, 1'b1, 1'b1);
    checkOutput("sticky_set_wins", {31'd0, err_sticky_out}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    checkOutput("sticky_cleared", {31'd0, err_sticky_out}, 32'd0);

    $display("[TB] reset while full");
    applyStimulus(1'b1, 3'd0, 32'd10, 32'h13, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 32'd11, 32'h13, 1'b0, 1'b0);
    checkOutput("full_before_reset", {31'd0, in_ready_out}, 32'd0);
    resetPulse();
    repeat (3) begin
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("no_stale_word", {31'd0, out_valid_out}, 32'd0);
    end
    applyStimulus(1'b1, 3'd4, 32'h12345000, 32'h37, 1'b0, 1'b0);
    checkOutput("first_after_reset", instr_out, 32'h12345037);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] imm;
      int pick;
      pick = $urandom_range(0, 3);
      case (pick)
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFFF000;
        default: imm = 32'($urandom_range(0, 40));
      endcase
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), imm, $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("[TB] counter wrap");
    resetPulse();
    for (int c = 0; c < 65536; c++)
      applyStimulus(1'b1, 3'd0, 32'($urandom_range(0, 2047)), 32'h13, 1'b1, 1'b0);
    checkOutput("count_wrap", {16'd0, enc_count_out}, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
